// File: rtl/uart_program_loader.sv
// Boot-time UART program loader: takes a 32-bit little-endian word-count header,
// packs the following bytes into 32-bit words and writes them to instruction memory.
module uart_program_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_ferr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic                  cpu_start,
    output logic                  load_err,
    output logic [1:0]            err_code
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [32:0]         MAX_WORDS = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FRAME = 2'd1;
    localparam logic [1:0] ERR_SIZE  = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [1:0]            next_err_s;
    logic                  take_byte_s;
    logic [31:0]           hdr_len_s;
    logic                  oversize_s;
    logic                  tmo_hit_s;
    logic                  all_written_s;

    logic [1:0]            byte_idx_r;
    logic [23:0]           hdr_r;
    logic [23:0]           word_r;
    logic [ADDR_WIDTH:0]   word_cnt_r;
    logic [ADDR_WIDTH:0]   n_words_r;
    logic [TMO_W-1:0]      tmo_cnt_r;

    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_wdata_r;
    logic                  busy_r;
    logic                  load_done_r;
    logic                  cpu_start_r;
    logic                  load_err_r;
    logic [1:0]            err_code_r;

    // The final header byte arrives on rx_data, so the count is formed combinationally.
    assign hdr_len_s     = {rx_data, hdr_r};
    assign oversize_s    = ({1'b0, hdr_len_s} > MAX_WORDS);
    assign tmo_hit_s     = (tmo_cnt_r == TMO_LAST);
    assign all_written_s = (word_cnt_r == n_words_r);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, error-code and byte-acceptance decode; framing error outranks a byte.
    always_comb begin
        next_state_s = state_r;
        next_err_s   = err_code_r;
        take_byte_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_ferr) begin
                    next_state_s = ST_ERROR;
                    next_err_s   = ERR_FRAME;
                end else if (rx_ready) begin
                    next_state_s = ST_HEADER;
                    take_byte_s  = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (rx_ferr) begin
                    next_state_s = ST_ERROR;
                    next_err_s   = ERR_FRAME;
                end else if (rx_ready) begin
                    take_byte_s = 1'b1;
                    if (byte_idx_r != 2'd3) begin
                        next_state_s = ST_HEADER;
                    end else if (hdr_len_s == 32'd0) begin
                        next_state_s = ST_DONE;
                    end else if (oversize_s) begin
                        next_state_s = ST_ERROR;
                        next_err_s   = ERR_SIZE;
                    end else begin
                        next_state_s = ST_DATA;
                    end
                end else if (tmo_hit_s) begin
                    next_state_s = ST_ERROR;
                    next_err_s   = ERR_TMO;
                end else begin
                    next_state_s = ST_HEADER;
                end
            end
            ST_DATA: begin
                // The counter already includes the word on the write port this cycle.
                if (all_written_s) begin
                    next_state_s = ST_DONE;
                end else if (rx_ferr) begin
                    next_state_s = ST_ERROR;
                    next_err_s   = ERR_FRAME;
                end else if (rx_ready) begin
                    next_state_s = ST_DATA;
                    take_byte_s  = 1'b1;
                end else if (tmo_hit_s) begin
                    next_state_s = ST_ERROR;
                    next_err_s   = ERR_TMO;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_DONE: begin
                next_state_s = ST_DONE;
            end
            ST_ERROR: begin
                next_state_s = ST_ERROR;
            end
            default: begin
                next_state_s = ST_IDLE;
                next_err_s   = ERR_NONE;
            end
        endcase
    end

    // Inter-byte idle counter, live only while a transfer is in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (((state_r == ST_HEADER) || (state_r == ST_DATA)) && !rx_ready) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // Header/word byte assembly, word counter and memory write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx_r  <= 2'd0;
            hdr_r       <= 24'd0;
            word_r      <= 24'd0;
            word_cnt_r  <= {(ADDR_WIDTH+1){1'b0}};
            n_words_r   <= {(ADDR_WIDTH+1){1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= 32'd0;
        end else begin
            mem_we_r <= 1'b0;
            if (take_byte_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                if (state_r == ST_DATA) begin
                    case (byte_idx_r)
                        2'd0:    word_r[7:0]   <= rx_data;
                        2'd1:    word_r[15:8]  <= rx_data;
                        2'd2:    word_r[23:16] <= rx_data;
                        default: begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= word_cnt_r[ADDR_WIDTH-1:0];
                            mem_wdata_r <= {rx_data, word_r};
                            word_cnt_r  <= word_cnt_r + CNT_ONE;
                        end
                    endcase
                end else begin
                    case (byte_idx_r)
                        2'd0:    hdr_r[7:0]   <= rx_data;
                        2'd1:    hdr_r[15:8]  <= rx_data;
                        2'd2:    hdr_r[23:16] <= rx_data;
                        default: n_words_r    <= hdr_len_s[ADDR_WIDTH:0];
                    endcase
                end
            end
        end
    end

    // Status outputs registered from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
            cpu_start_r <= 1'b0;
            load_err_r  <= 1'b0;
            err_code_r  <= ERR_NONE;
        end else begin
            busy_r      <= (next_state_s == ST_HEADER) || (next_state_s == ST_DATA);
            load_done_r <= (next_state_s == ST_DONE);
            cpu_start_r <= (next_state_s == ST_DONE) && (state_r != ST_DONE);
            load_err_r  <= (next_state_s == ST_ERROR);
            err_code_r  <= next_err_s;
        end
    end

    // A write pending from the previous edge is suppressed while reset is held.
    assign mem_we    = mem_we_r && !reset;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign load_done = load_done_r;
    assign cpu_start = cpu_start_r;
    assign load_err  = load_err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: transaction-level reference model compared against
// every output each cycle, plus literal expectations for the directed scenarios.
module tb_uart_program_loader;

    localparam int AW  = 4;
    localparam int TMO = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          rx_ferr;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          load_done;
    logic          cpu_start;
    logic          load_err;
    logic [1:0]    err_code;

    always #5 clock = ~clock;

    uart_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_ferr(rx_ferr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .load_done(load_done), .cpu_start(cpu_start),
        .load_err(load_err), .err_code(err_code)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases plus a byte queue; a full header/word is decoded from four bytes.
    typedef enum int {M_IDLE, M_HDR, M_DATA, M_DONE, M_ERR} mphase_t;
    mphase_t       ph = M_IDLE;
    logic [7:0]    bq[$];
    int unsigned   n_words = 0;
    int unsigned   written = 0;
    int unsigned   gap = 0;
    logic          e_we = 1'b0;
    logic          e_start = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0]   e_wdata = 32'd0;
    logic [1:0]    e_err = 2'd0;
    logic [31:0]   mw;
    bit            model_live = 1'b0;

    always @(posedge clock) begin
        e_we = 1'b0;
        e_start = 1'b0;
        if (reset) begin
            ph = M_IDLE; bq.delete(); n_words = 0; written = 0; gap = 0;
            e_addr = '0; e_wdata = 32'd0; e_err = 2'd0; model_live = 1'b1;
        end else if (ph == M_IDLE || ph == M_HDR || ph == M_DATA) begin
            if (ph == M_DATA && written == n_words) begin
                ph = M_DONE; e_start = 1'b1;
            end else if (rx_ferr) begin
                ph = M_ERR; e_err = 2'd1;
            end else if (rx_ready) begin
                gap = 0;
                bq.push_back(rx_data);
                if (ph == M_IDLE) begin
                    ph = M_HDR;
                end else if (bq.size() == 4) begin
                    mw = {bq[3], bq[2], bq[1], bq[0]};
                    bq.delete();
                    if (ph == M_HDR) begin
                        if (mw == 32'd0) begin ph = M_DONE; e_start = 1'b1; end
                        else if (mw > (32'd1 << AW)) begin ph = M_ERR; e_err = 2'd2; end
                        else begin ph = M_DATA; n_words = mw; end
                    end else begin
                        e_we = 1'b1; e_addr = written[AW-1:0]; e_wdata = mw; written++;
                    end
                end
            end else if (ph != M_IDLE) begin
                gap++;
                if (gap == TMO) begin ph = M_ERR; e_err = 2'd3; end
            end
        end
    end

    // Every output checked against the model mid-cycle.
    always @(negedge clock) begin
        if (model_live) begin
            check("mem_we", {31'd0, mem_we}, {31'd0, e_we && !reset});
            check("mem_addr", {28'd0, mem_addr}, {28'd0, e_addr});
            check("mem_wdata", mem_wdata, e_wdata);
            check("busy", {31'd0, busy}, {31'd0, (ph == M_HDR || ph == M_DATA)});
            check("load_done", {31'd0, load_done}, {31'd0, (ph == M_DONE)});
            check("cpu_start", {31'd0, cpu_start}, {31'd0, e_start});
            check("load_err", {31'd0, load_err}, {31'd0, (ph == M_ERR)});
            check("err_code", {30'd0, err_code}, {30'd0, e_err});
        end
    end

    // Observed write image and pulse counts, used by the literal checks.
    logic [31:0] obs_mem [0:(1<<AW)-1];
    int we_cnt = 0;
    int start_cnt = 0;
    always @(negedge clock) begin
        if (mem_we) begin
            obs_mem[mem_addr] = mem_wdata;
            we_cnt++;
        end
        if (cpu_start) start_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic ferr);
        rx_ready = 1'b1; rx_data = b; rx_ferr = ferr;
        tick(1);
        rx_ready = 1'b0; rx_ferr = 1'b0; rx_data = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8], 1'b0);
            tick($urandom_range(maxgap, 0));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        we_cnt = 0;
        start_cnt = 0;
        for (int i = 0; i < (1 << AW); i++) obs_mem[i] = 32'hxxxxxxxx;
    endtask

    logic [31:0] words [0:(1<<AW)-1];
    logic [7:0]  stream[$];

    initial begin
        reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; rx_ferr = 1'b0;
        tick(3);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {30'd0, err_code}, 32'd0);
        do_reset();

        // Two-word load.
        send_word(32'd2, 2);
        send_word(32'h00000013, 2);
        send_word(32'hDEADBEEF, 2);
        tick(4);
        check("t1_addr0", obs_mem[0], 32'h00000013);
        check("t1_addr1", obs_mem[1], 32'hDEADBEEF);
        check("t1_writes", we_cnt, 32'd2);
        check("t1_start", start_cnt, 32'd1);
        check("t1_done", {31'd0, load_done}, 32'd1);
        for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
        tick(2);
        check("t1_post_done_writes", we_cnt, 32'd2);
        check("t1_post_done_start", start_cnt, 32'd1);

        // Empty program.
        do_reset();
        send_word(32'd0, 0);
        check("t2_done_next", {31'd0, load_done}, 32'd1);
        check("t2_start_next", {31'd0, cpu_start}, 32'd1);
        tick(3);
        check("t2_start_once", start_cnt, 32'd1);
        check("t2_writes", we_cnt, 32'd0);

        // Oversize header.
        do_reset();
        send_word(32'h11, 1);
        tick(2);
        check("t3_err", {31'd0, load_err}, 32'd1);
        check("t3_code", {30'd0, err_code}, 32'd2);
        send_word(32'h12345678, 0);
        tick(2);
        check("t3_writes", we_cnt, 32'd0);

        // Exactly 2**AW words fills memory.
        do_reset();
        send_word(32'd16, 1);
        for (int k = 0; k < 16; k++) begin
            words[k] = $urandom;
            send_word(words[k], 1);
        end
        tick(3);
        check("t3b_writes", we_cnt, 32'd16);
        check("t3b_done", {31'd0, load_done}, 32'd1);
        check("t3b_first", obs_mem[0], words[0]);
        check("t3b_last", obs_mem[15], words[15]);

        // Timeout after two data bytes; later bytes ignored.
        do_reset();
        send_word(32'd1, 1);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        tick(TMO + 5);
        check("t4_err", {31'd0, load_err}, 32'd1);
        check("t4_code", {30'd0, err_code}, 32'd3);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        tick(2);
        check("t4_writes", we_cnt, 32'd0);

        // Bytes arriving on the expiry cycle are accepted.
        do_reset();
        send_word(32'd1, 0);
        for (int i = 0; i < 4; i++) begin
            tick(TMO - 1);
            send(8'h41 + 8'(i), 1'b0);
        end
        tick(3);
        check("t4b_err", {31'd0, load_err}, 32'd0);
        check("t4b_word", obs_mem[0], 32'h44434241);
        check("t4b_done", {31'd0, load_done}, 32'd1);

        // Framing error with the third data byte.
        do_reset();
        send_word(32'd1, 0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        tick(2);
        check("t5_code", {30'd0, err_code}, 32'd1);
        check("t5_writes", we_cnt, 32'd0);

        // Framing error on a word's fourth byte suppresses that write.
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h01020304, 0);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b1);
        tick(2);
        check("t5b_code", {30'd0, err_code}, 32'd1);
        check("t5b_writes", we_cnt, 32'd1);

        // Reset mid-load, then a clean single-word load.
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h0BADF00D, 0);
        send(8'h99, 1'b0);
        do_reset();
        send_word(32'd1, 1);
        send_word(32'hCAFEF00D, 1);
        tick(3);
        check("t6_word", obs_mem[0], 32'hCAFEF00D);
        check("t6_writes", we_cnt, 32'd1);
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
        tick(2);
        check("t6_post_done_writes", we_cnt, 32'd1);

        // Reset asserted in the write cycle masks mem_we.
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h5A5A5A5A, 0);
        reset = 1'b1;
        #1;
        check("we_in_reset", {31'd0, mem_we}, 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        check("we_in_reset_cnt", we_cnt, 32'd0);
        check("we_in_reset_busy", {31'd0, busy}, 32'd0);

        // Randomized loads, some with an injected framing error.
        for (int it = 0; it < 20; it++) begin
            int n;
            int fault_at;
            do_reset();
            n = $urandom_range(16, 0);
            stream.delete();
            for (int i = 0; i < 4; i++) stream.push_back(8'(n >> (8 * i)));
            for (int k = 0; k < n; k++) begin
                words[k] = $urandom;
                for (int i = 0; i < 4; i++) stream.push_back(words[k][8*i +: 8]);
            end
            fault_at = ($urandom_range(3, 0) == 3) ? int'($urandom_range(stream.size() - 1, 0)) : -1;
            for (int i = 0; i < stream.size(); i++) begin
                send(stream[i], (i == fault_at));
                if (i == fault_at) break;
                tick($urandom_range(3, 0));
            end
            tick(3);
            if (fault_at >= 0) begin
                check("rnd_ferr_code", {30'd0, err_code}, 32'd1);
            end else begin
                check("rnd_writes", we_cnt, n);
                check("rnd_start", start_cnt, 32'd1);
                for (int k = 0; k < n; k++) check("rnd_word", obs_mem[k], words[k]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
